mem_read_streamer: RTL and testbench
====================================

Name: mem_read_streamer

Overview:
- Upstream producer for the skid FIFO (fifo) write port.
- On a start command, issues a burst of sequential word reads to a fixed-latency pipelined memory.
- Forwards the returned data as FIFO writes.
- Paces itself on the FIFO ready signal; the FIFO skid slots absorb reads already in flight when ready drops.

Parameters:
- ADDR_WIDTH, 32, word-address width.
- LEN_WIDTH, 16, burst-length field width (words).
- DATA_WIDTH, 32, memory and FIFO data width.
- MEM_LATENCY, 2, cycles from memRdEnOut to valid memRdDataIn; must satisfy MEM_LATENCY+1 <= FIFO_SKID.
- FIFO_SKID, 4, skid depth of the downstream FIFO; used only for the elaboration check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- startIn  in  1  one-cycle start pulse; accepted only in IDLE
- baseAddrIn  in  ADDR_WIDTH  first word address; sampled with startIn
- lenIn  in  LEN_WIDTH  number of words; sampled with startIn; 0 means no reads
- busyOut  out  1  high from accepted start until the last write has left
- doneOut  out  1  one-cycle pulse after the last FIFO write
- memAddrOut  out  ADDR_WIDTH  read address
- memRdEnOut  out  1  read request strobe
- memRdDataIn  in  DATA_WIDTH  read data, valid exactly MEM_LATENCY cycles after memRdEnOut
- wrDataOut  out  DATA_WIDTH  FIFO write data
- wrValidOut  out  1  FIFO write strobe
- wrReadyIn  in  1  FIFO has at least FIFO_SKID free slots

Behaviour:
- Reset state: all outputs 0, state IDLE, address counter 0, remaining count 0, in-flight pipeline cleared.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - startIn with lenIn != 0: latch the address and length; go to ISSUE; busyOut rises the next cycle.
  - startIn with lenIn == 0: stay in IDLE; pulse doneOut the next cycle; busyOut stays 0.
- ISSUE:
  - Read condition: wrReadyIn is high in a cycle.
  - When the condition holds, memRdEnOut=1, memAddrOut=current address; the address increments and the remaining count decrements.
  - wrReadyIn is used combinationally; no read is issued in a cycle where it is low.
  - After the last request issues (remaining count 1 -> 0), go to DRAIN.
- DRAIN: wait until the in-flight pipeline is empty, then pulse doneOut, drop busyOut, and return to IDLE. The doneOut pulse and busyOut fall occur in the same cycle, one cycle after the last wrValidOut.
- Return path:
  - memRdEnOut passes through a MEM_LATENCY-deep valid shift register.
  - wrValidOut = shifted valid; wrDataOut = memRdDataIn.
  - Pure wiring, registered only by the memory. Total issue-to-write latency is MEM_LATENCY.
  - wrValidOut is never gated by wrReadyIn; the skid guarantees space for it.
- startIn outside IDLE is ignored; there is no queuing.
- Address wraps modulo 2^ADDR_WIDTH without error.
- In-flight count is at most MEM_LATENCY. It is tracked by an up/down counter of width clog2(MEM_LATENCY+1), used for DRAIN exit.
- rst mid-burst:
  - Abandons the burst immediately.
  - In-flight valids are cleared, so no stale wrValidOut appears after reset.
  - No doneOut pulse.
- Elaboration error if MEM_LATENCY+1 > FIFO_SKID.

Optional Feature:
- Macro: MEM_READ_STREAMER_STATS_EN.
- When defined, adds the following outputs:
  - stallCountOut (32): counts ISSUE cycles with wrReadyIn low. It is cleared on an accepted start and on rst, saturates at 0xFFFFFFFF, and holds its value after done.
  - wordCountOut (LEN_WIDTH): counts FIFO writes in the current burst, cleared on start.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package mem_read_streamer_pkg:
  - state enum (IDLE, ISSUE, DRAIN);
  - default width constants;
  - a function computing the in-flight counter width.
- Sub-module: reuse the existing delay (DATA_WIDTH=1, LATENCY=MEM_LATENCY) for the valid shift register.
- FSM, counters, and the optional stats logic stay in the top module.

Test Plan:
- Base burst:
  - Stimulus: wrReadyIn held 1; start baseAddr=0x100, len=8; memory model returns data=addr.
  - Response: reads at 0x100..0x107 on 8 consecutive cycles; wrValidOut 8 cycles, each MEM_LATENCY after its read, with data 0x100..0x107; doneOut one cycle after the last write.
- Backpressure:
  - Stimulus: len=64; wrReadyIn toggled randomly at 50%; downstream is the real fifo (FIFO_DEPTH=32, FIFO_SKID=4) drained randomly.
  - Response: no FIFO overflow; read-side sequence is 0..63 in order; memRdEnOut never high while wrReadyIn is low.
- Zero length:
  - Stimulus: start with len=0.
  - Response: no memRdEnOut; doneOut pulses once; busyOut stays 0.
- Ignored start and wrap:
  - Stimulus: start base=0xFFFFFFFE, len=4; a second start is asserted mid-burst.
  - Response: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; the second start has no effect.
- Reset mid-burst:
  - Stimulus: assert rst after 3 of 10 reads issue.
  - Response: all outputs 0 the next cycle; no wrValidOut after reset; no doneOut; a fresh start afterwards behaves as the base burst.
- Stats (macro defined):
  - Stimulus: len=16 with wrReadyIn low for exactly 5 ISSUE cycles.
  - Response: stallCountOut=5 and wordCountOut=16 at doneOut.

Source files
------------

// File: rtl/mem_read_streamer_pkg.sv
// Shared types and constants for the memory read streamer.
package mem_read_streamer_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_LEN_WIDTH   = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_MEM_LATENCY = 2;
    localparam int unsigned DEFAULT_FIFO_SKID   = 4;
    localparam int unsigned STATS_WIDTH         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } streamerStateT;

    // Width of a counter holding 0..latency reads in flight.
    function automatic int unsigned inFlightWidth(input int unsigned latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_read_streamer_delay.sv
// Fixed-latency shift register; every stage clears on reset.
module delay #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut
);

    logic [DATA_WIDTH-1:0] pipe [LATENCY];

    // Shift data one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= dataIn;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dataOut = pipe[LATENCY-1];

endmodule

// File: rtl/mem_read_streamer.sv
// Burst reader: streams sequential words from a fixed-latency memory into the
// skid FIFO write port. Optional counters enabled by MEM_READ_STREAMER_STATS_EN.
module mem_read_streamer
    import mem_read_streamer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH   = DEFAULT_LEN_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int unsigned FIFO_SKID   = DEFAULT_FIFO_SKID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] baseAddrIn,
    input  logic [LEN_WIDTH-1:0]  lenIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    output logic                  memRdEnOut,
    input  logic [DATA_WIDTH-1:0] memRdDataIn,
    output logic [DATA_WIDTH-1:0] wrDataOut,
    output logic                  wrValidOut,
    input  logic                  wrReadyIn
`ifdef MEM_READ_STREAMER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] stallCountOut,
    output logic [LEN_WIDTH-1:0]   wordCountOut
`endif
);

    localparam int unsigned IF_W = inFlightWidth(MEM_LATENCY);

    // Reads in flight must fit in the FIFO skid slots.
    if (MEM_LATENCY + 1 > FIFO_SKID) begin : gBadSkid
        $error("mem_read_streamer: MEM_LATENCY+1 exceeds FIFO_SKID");
    end
    if (MEM_LATENCY < 1) begin : gBadLatency
        $error("mem_read_streamer: MEM_LATENCY must be at least 1");
    end

    streamerStateT         state;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [IF_W-1:0]       inFlight;
    logic [IF_W-1:0]       inFlightNext;
    logic                  rdEn;

    // Ready gates the request in the same cycle so no read issues without space.
    assign rdEn       = (state == ISSUE) && wrReadyIn;
    assign memRdEnOut = rdEn;
    assign memAddrOut = addrReg;
    assign wrDataOut  = memRdDataIn;

    // Valid tracks each request through the memory latency.
    delay #(
        .DATA_WIDTH(1),
        .LATENCY   (MEM_LATENCY)
    ) uValidDelay (
        .clk    (clk),
        .rst    (rst),
        .dataIn (rdEn),
        .dataOut(wrValidOut)
    );

    // Next in-flight count; DRAIN exits on it so done lands one cycle after the last write.
    always_comb begin
        inFlightNext = inFlight;
        case ({rdEn, wrValidOut})
            2'b10:   inFlightNext = inFlight + IF_W'(1);
            2'b01:   inFlightNext = inFlight - IF_W'(1);
            default: inFlightNext = inFlight;
        endcase
    end

    // Control FSM with address/length counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addrReg   <= '0;
            remaining <= '0;
            inFlight  <= '0;
            busyOut   <= 1'b0;
            doneOut   <= 1'b0;
        end else begin
            doneOut  <= 1'b0;
            inFlight <= inFlightNext;
            case (state)
                IDLE: begin
                    if (startIn) begin
                        if (lenIn != '0) begin
                            addrReg   <= baseAddrIn;
                            remaining <= lenIn;
                            busyOut   <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            doneOut <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (rdEn) begin
                        addrReg   <= addrReg + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inFlightNext == '0) begin
                        doneOut <= 1'b1;
                        busyOut <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_READ_STREAMER_STATS_EN
    // Per-burst stall and write counters; cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCountOut <= '0;
            wordCountOut  <= '0;
        end else if (state == IDLE && startIn) begin
            stallCountOut <= '0;
            wordCountOut  <= '0;
        end else begin
            if (state == ISSUE && !wrReadyIn && stallCountOut != '1) begin
                stallCountOut <= stallCountOut + STATS_WIDTH'(1);
            end
            if (wrValidOut) begin
                wordCountOut <= wordCountOut + LEN_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_streamer.sv
// Self-checking bench for mem_read_streamer: table of bursts plus reset corner case.
module tb_mem_read_streamer;

    localparam int unsigned AW    = 32;
    localparam int unsigned LW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned SKID  = 4;
    localparam int          FDEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          startIn;
    logic [AW-1:0] baseAddrIn;
    logic [LW-1:0] lenIn;
    logic          busyOut;
    logic          doneOut;
    logic [AW-1:0] memAddrOut;
    logic          memRdEnOut;
    logic [DW-1:0] memRdDataIn;
    logic [DW-1:0] wrDataOut;
    logic          wrValidOut;
    logic          wrReadyIn;
`ifdef MEM_READ_STREAMER_STATS_EN
    logic [31:0]   stallCountOut;
    logic [LW-1:0] wordCountOut;
`endif

    mem_read_streamer #(
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DATA_WIDTH (DW),
        .MEM_LATENCY(LAT),
        .FIFO_SKID  (SKID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startIn    (startIn),
        .baseAddrIn (baseAddrIn),
        .lenIn      (lenIn),
        .busyOut    (busyOut),
        .doneOut    (doneOut),
        .memAddrOut (memAddrOut),
        .memRdEnOut (memRdEnOut),
        .memRdDataIn(memRdDataIn),
        .wrDataOut  (wrDataOut),
        .wrValidOut (wrValidOut),
        .wrReadyIn  (wrReadyIn)
`ifdef MEM_READ_STREAMER_STATS_EN
        ,
        .stallCountOut(stallCountOut),
        .wordCountOut (wordCountOut)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Memory model: two-stage pipeline returning data equal to the address.
    logic [DW-1:0] memP0 = '0;
    logic [DW-1:0] memP1 = '0;
    always @(posedge clk) begin
        memP0 <= memRdEnOut ? memAddrOut : 32'hDEAD_BEEF;
        memP1 <= memP0;
    end
    assign memRdDataIn = memP1;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } expT;
    expT q[$];

    int            readCnt;
    int            writeCnt;
    int            doneCnt;
    int            doneCycle;
    bit            busySeen;
    logic [AW-1:0] expAddr;

    // Monitor/scoreboard: push on request, pop and compare on write.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (memRdEnOut) begin
                check("rdEnGated", 64'(wrReadyIn), 64'd1);
                check("rdAddr", 64'(memAddrOut), 64'(expAddr));
                q.push_back('{memAddrOut, cycle + LAT});
                expAddr = expAddr + 32'd1;
                readCnt++;
            end
            if (wrValidOut) begin
                expT e;
                writeCnt++;
                if (q.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpectedWrite: got data 0x%0h expected no write", wrDataOut);
                end else begin
                    e = q.pop_front();
                    check("wrData", 64'(wrDataOut), 64'(e.data));
                    check("wrCycle", 64'(cycle), 64'(e.cyc));
                end
            end
            if (doneOut) begin
                doneCnt++;
                doneCycle = cycle;
                check("busyAtDone", 64'(busyOut), 64'd0);
            end
            if (busyOut) busySeen = 1'b1;
        end
    end

    typedef struct {
        string         name;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            mode;     // 0 ready, 1 random + fifo model, 2 five stall cycles
        bit            midStart;
    } vecT;

    task automatic resetCounters();
        readCnt  = 0;
        writeCnt = 0;
        doneCnt  = 0;
        busySeen = 1'b0;
    endtask

    task automatic runBurst(input vecT v);
        int startCyc;
        int occ;
        int maxOcc;
        int stallExp;
        bit timedOut;
        resetCounters();
        expAddr  = v.base;
        occ      = 0;
        maxOcc   = 0;
        stallExp = 0;
        timedOut = 1'b1;
        @(posedge clk); #1;
        startIn    = 1'b1;
        baseAddrIn = v.base;
        lenIn      = v.len;
        wrReadyIn  = (v.mode != 1);
        startCyc   = cycle;
        @(posedge clk); #1;
        for (int i = 1; i < 3000; i++) begin
            if (v.midStart && i == 2) begin
                startIn    = 1'b1;
                baseAddrIn = 32'h500;
                lenIn      = 16'd7;
            end else begin
                startIn = 1'b0;
            end
            case (v.mode)
                1: begin
                    int pop;
                    pop = (occ > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
                    occ = occ + (wrValidOut ? 1 : 0) - pop;
                    if (occ > maxOcc) maxOcc = occ;
                    wrReadyIn = ($urandom_range(0, 1) == 1) && (FDEPTH - occ >= int'(SKID));
                end
                2: wrReadyIn = !(i >= 3 && i <= 7);
                default: wrReadyIn = 1'b1;
            endcase
            if (!wrReadyIn && readCnt < int'(v.len)) stallExp++;
            @(posedge clk); #1;
            if (doneCnt != 0) begin
                timedOut = 1'b0;
                break;
            end
        end
        if (timedOut) begin
            nChecks++;
            nFail++;
            $display("FAIL %s_timeout: got no doneOut expected doneOut", v.name);
        end
        wrReadyIn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({v.name, "_reads"}, 64'(readCnt), 64'(v.len));
        check({v.name, "_writes"}, 64'(writeCnt), 64'(v.len));
        check({v.name, "_doneCount"}, 64'(doneCnt), 64'd1);
        check({v.name, "_busySeen"}, 64'(busySeen), 64'(v.len != 0));
        check({v.name, "_busyAfter"}, 64'(busyOut), 64'd0);
        check({v.name, "_qEmpty"}, 64'(q.size()), 64'd0);
        if (v.mode == 0)
            check({v.name, "_doneLatency"}, 64'(doneCycle - startCyc),
                  64'((v.len == 0) ? 1 : int'(v.len) + LAT + 1));
        if (v.mode == 1)
            check({v.name, "_noOverflow"}, 64'(maxOcc <= FDEPTH), 64'd1);
`ifdef MEM_READ_STREAMER_STATS_EN
        check({v.name, "_stallCount"}, 64'(stallCountOut), 64'(stallExp));
        check({v.name, "_wordCount"}, 64'(wordCountOut), 64'(v.len));
`endif
    endtask

    task automatic resetMidBurst();
        bit reached;
        resetCounters();
        expAddr = 32'h200;
        reached = 1'b0;
        @(posedge clk); #1;
        startIn    = 1'b1;
        baseAddrIn = 32'h200;
        lenIn      = 16'd10;
        wrReadyIn  = 1'b1;
        @(posedge clk); #1;
        startIn = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (readCnt >= 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rstMid_reached3", 64'(reached), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("rstMid_busy", 64'(busyOut), 64'd0);
        check("rstMid_done", 64'(doneOut), 64'd0);
        check("rstMid_rdEn", 64'(memRdEnOut), 64'd0);
        check("rstMid_wrValid", 64'(wrValidOut), 64'd0);
        check("rstMid_addr", 64'(memAddrOut), 64'd0);
        writeCnt = 0;
        doneCnt  = 0;
        readCnt  = 0;
        repeat (6) @(posedge clk);
        #1;
        check("rstMid_noWrites", 64'(writeCnt), 64'd0);
        check("rstMid_noDone", 64'(doneCnt), 64'd0);
        check("rstMid_noReads", 64'(readCnt), 64'd0);
    endtask

    vecT vecs[7];

    initial begin
        vecs[0] = '{"base",   32'h100,       16'd8,  0, 1'b0};
        vecs[1] = '{"zero",   32'h80,        16'd0,  0, 1'b0};
        vecs[2] = '{"wrap",   32'hFFFF_FFFE, 16'd4,  0, 1'b1};
        vecs[3] = '{"single", 32'h40,        16'd1,  0, 1'b0};
        vecs[4] = '{"bkpr",   32'h0,         16'd64, 1, 1'b0};
        vecs[5] = '{"stall",  32'h300,       16'd16, 2, 1'b0};
        vecs[6] = '{"short",  32'h1234,      16'd3,  0, 1'b1};

        rst        = 1'b1;
        startIn    = 1'b0;
        baseAddrIn = '0;
        lenIn      = '0;
        wrReadyIn  = 1'b0;
        resetCounters();
        expAddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busyOut), 64'd0);
        check("reset_done", 64'(doneOut), 64'd0);
        check("reset_rdEn", 64'(memRdEnOut), 64'd0);
        check("reset_wrValid", 64'(wrValidOut), 64'd0);
        check("reset_addr", 64'(memAddrOut), 64'd0);
        rst = 1'b0;

        foreach (vecs[k]) runBurst(vecs[k]);

        resetMidBurst();
        runBurst(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
